// File: rtl/nes_pad_reader.sv
// NES gamepad serial reader: latches the pad, clocks in its 8 buttons and presents them as held levels.
// Optional NES_PAD_DEBOUNCE_EN: outputs only update after two identical consecutive polls.
module nes_pad_reader #(
    parameter int HALF_PERIOD = 150,
    parameter int POLL_DIV    = 416667
) (
    input  logic clk,
    input  logic rst,
    input  logic pad_data,
    output logic pad_latch,
    output logic pad_clk,
    output logic a,
    output logic b,
    output logic select,
    output logic start,
    output logic up,
    output logic down,
    output logic left,
    output logic right,
    output logic buttons_valid
);

    localparam int PW = $clog2(POLL_DIV);
    localparam int HW = $clog2(2 * HALF_PERIOD);

    localparam logic [PW-1:0] POLL_LAST  = PW'(POLL_DIV - 1);
    localparam logic [PW-1:0] POLL_ZERO  = {PW{1'b0}};
    localparam logic [PW-1:0] POLL_ONE   = {{(PW-1){1'b0}}, 1'b1};
    localparam logic [HW-1:0] HALF_LAST  = HW'(HALF_PERIOD - 1);
    localparam logic [HW-1:0] LATCH_LAST = HW'(2 * HALF_PERIOD - 1);
    localparam logic [HW-1:0] PHASE_ZERO = {HW{1'b0}};
    localparam logic [HW-1:0] PHASE_ONE  = {{(HW-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_LOW    = 3'd2,
        ST_HIGH   = 3'd3,
        ST_UPDATE = 3'd4
    } state_t;

    generate
        if (HALF_PERIOD < 4) begin : g_bad_half_period
            $error("nes_pad_reader: HALF_PERIOD must be at least 4");
        end
        if (POLL_DIV <= 18 * HALF_PERIOD + 1) begin : g_bad_poll_div
            $error("nes_pad_reader: POLL_DIV must exceed one full frame (18*HALF_PERIOD+1)");
        end
    endgenerate

    state_t          state_r;
    state_t          state_s;
    logic [HW-1:0]   phase_r;
    logic [HW-1:0]   phase_s;
    logic [2:0]      bit_idx_r;
    logic [2:0]      bit_idx_s;
    logic [PW-1:0]   poll_cnt_r;
    logic            poll_tick_s;
    logic            sample_s;
    logic            enter_update_s;
    logic            commit_s;
    logic            sync_meta_r;
    logic            sync_data_r;
    logic [7:0]      shift_r;
    logic [7:0]      btn_r;
    logic            buttons_valid_r;
    logic            pad_latch_r;
    logic            pad_clk_r;

    assign poll_tick_s    = (poll_cnt_r == POLL_LAST);
    assign enter_update_s = (state_s == ST_UPDATE);

    // Two-flop synchroniser for the asynchronous pad data line; idles released (high).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta_r <= 1'b1;
            sync_data_r <= 1'b1;
        end else begin
            sync_meta_r <= pad_data;
            sync_data_r <= sync_meta_r;
        end
    end

    // Free-running poll divider.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            poll_cnt_r <= POLL_ZERO;
        end else if (poll_tick_s) begin
            poll_cnt_r <= POLL_ZERO;
        end else begin
            poll_cnt_r <= poll_cnt_r + POLL_ONE;
        end
    end

    // Frame sequencer: next state, phase/bit counters and sample strobe.
    always_comb begin
        state_s   = state_r;
        phase_s   = phase_r + PHASE_ONE;
        bit_idx_s = bit_idx_r;
        sample_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                phase_s = PHASE_ZERO;
                if (poll_tick_s) begin
                    state_s = ST_LATCH;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_LATCH: begin
                if (phase_r == LATCH_LAST) begin
                    state_s   = ST_LOW;
                    phase_s   = PHASE_ZERO;
                    bit_idx_s = 3'd0;
                end else begin
                    state_s = ST_LATCH;
                end
            end
            ST_LOW: begin
                // Sample on the last low cycle: the pad output has had the whole half-period to settle.
                if (phase_r == HALF_LAST) begin
                    sample_s = 1'b1;
                    state_s  = ST_HIGH;
                    phase_s  = PHASE_ZERO;
                end else begin
                    state_s = ST_LOW;
                end
            end
            ST_HIGH: begin
                if (phase_r == HALF_LAST) begin
                    phase_s = PHASE_ZERO;
                    if (bit_idx_r == 3'd7) begin
                        state_s = ST_UPDATE;
                    end else begin
                        state_s   = ST_LOW;
                        bit_idx_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    state_s = ST_HIGH;
                end
            end
            ST_UPDATE: begin
                state_s = ST_IDLE;
                phase_s = PHASE_ZERO;
            end
            default: begin
                state_s   = ST_IDLE;
                phase_s   = PHASE_ZERO;
                bit_idx_s = 3'd0;
            end
        endcase
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            phase_r   <= PHASE_ZERO;
            bit_idx_r <= 3'd0;
        end else begin
            state_r   <= state_s;
            phase_r   <= phase_s;
            bit_idx_r <= bit_idx_s;
        end
    end

    // Pad lines are registered from the next state so they track the state without a cycle of lag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pad_latch_r <= 1'b0;
            pad_clk_r   <= 1'b1;
        end else begin
            pad_latch_r <= (state_s == ST_LATCH);
            pad_clk_r   <= (state_s != ST_LOW);
        end
    end

    // Internal shift register; pad data is active-low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_r <= 8'h00;
        end else if (sample_s) begin
            shift_r[bit_idx_r] <= ~sync_data_r;
        end
    end

`ifdef NES_PAD_DEBOUNCE_EN
    logic [7:0] prev_r;

    // Previous frame sample, always replaced at the end of each frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_r <= 8'h00;
        end else if (enter_update_s) begin
            prev_r <= shift_r;
        end
    end

    assign commit_s = enter_update_s && (shift_r == prev_r);
`else
    assign commit_s = enter_update_s;
`endif

    // Button outputs and valid strobe, live during the UPDATE cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_r           <= 8'h00;
            buttons_valid_r <= 1'b0;
        end else begin
            buttons_valid_r <= commit_s;
            if (commit_s) begin
                btn_r <= shift_r;
            end
        end
    end

    assign pad_latch     = pad_latch_r;
    assign pad_clk       = pad_clk_r;
    assign buttons_valid = buttons_valid_r;
    assign a             = btn_r[0];
    assign b             = btn_r[1];
    assign select        = btn_r[2];
    assign start         = btn_r[3];
    assign up            = btn_r[4];
    assign down          = btn_r[5];
    assign left          = btn_r[6];
    assign right         = btn_r[7];

endmodule

// File: tb/tb_nes_pad_reader.sv
// Self-checking bench for nes_pad_reader: a behavioural pad drives the serial line and a frame-level
// model predicts button outputs, strobe timing and pad-line waveforms.
module tb_nes_pad_reader;

    localparam int HP    = 4;
    localparam int PD    = 100;
    localparam int FRAME = 18 * HP + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pad_data;
    logic pad_latch, pad_clk;
    logic a, b, select, start, up, down, left, right, buttons_valid;
    logic [7:0] got_btn;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] pressed     = 8'h00;
    logic [7:0] toggle_mask = 8'h00;
    logic [3:0] pad_idx     = 4'd8;
    logic [7:0] shown_m     = 8'h00;
    logic [7:0] prev_m      = 8'h00;
    int         last_latch  = 0;

    nes_pad_reader #(.HALF_PERIOD(HP), .POLL_DIV(PD)) dut (
        .clk(clk), .rst(rst), .pad_data(pad_data),
        .pad_latch(pad_latch), .pad_clk(pad_clk),
        .a(a), .b(b), .select(select), .start(start),
        .up(up), .down(down), .left(left), .right(right),
        .buttons_valid(buttons_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign got_btn = {right, left, down, up, start, select, b, a};

    // Pad: latch loads the buttons, each pad_clk rise advances to the next one, data active-low.
    always @(posedge pad_clk or posedge pad_latch) begin
        if (pad_latch) pad_idx <= 4'd0;
        else if (pad_idx != 4'd8) pad_idx <= pad_idx + 4'd1;
    end
    assign pad_data = (pad_idx < 4'd8) ? ~pressed[pad_idx[2:0]] : 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Wait for the next latch rise, checking the outputs hold and no strobe appears meanwhile.
    task automatic wait_latch();
        int hold_err = 0;
        int stray    = 0;
        bit found    = 1'b0;
        for (int i = 0; i < 2 * PD && !found; i++) begin
            @(negedge clk);
            if (i == 3 && toggle_mask != 8'h00) begin
                pressed     = pressed ^ toggle_mask;
                toggle_mask = 8'h00;
            end
            if (pad_latch) found = 1'b1;
            else begin
                if (got_btn !== shown_m) hold_err++;
                if (buttons_valid) stray++;
            end
        end
        check_eq("latch_seen", found, 1);
        check_eq("poll_period", cyc - last_latch, PD);
        check_eq("gap_hold", hold_err, 0);
        check_eq("gap_valid", stray, 0);
    endtask

    // Observe one frame from the latch rise; the model takes the buttons held at latch time.
    task automatic run_frame();
        logic [7:0] snap, exp_new;
        logic upd;
        int latch_w = 0, low_cyc = 0, pulses = 0, bad_w = 0, run_w = 0;
        int valid_cnt = 0, valid_k = -1, hold_err = 0, late_err = 0;
        int latch_cyc;
        logic prev_clk = 1'b1;
        snap = pressed;
`ifdef NES_PAD_DEBOUNCE_EN
        upd = (snap == prev_m);
`else
        upd = 1'b1;
`endif
        prev_m    = snap;
        exp_new   = upd ? snap : shown_m;
        latch_cyc = cyc;
        for (int k = 0; k < 85; k++) begin
            if (k > 0) @(negedge clk);
            if (pad_latch) latch_w++;
            if (!pad_clk) begin
                low_cyc++;
                run_w++;
                if (prev_clk) pulses++;
            end else if (!prev_clk) begin
                if (run_w != HP) bad_w++;
                run_w = 0;
            end
            prev_clk = pad_clk;
            if (buttons_valid) begin
                valid_cnt++;
                valid_k = k;
            end
            if (valid_cnt == 0) begin
                if (got_btn !== shown_m) hold_err++;
            end else if (got_btn !== exp_new) late_err++;
        end
        check_eq("latch_width", latch_w, 2 * HP);
        check_eq("clk_pulses", pulses, 8);
        check_eq("clk_low_cycles", low_cyc, 8 * HP);
        check_eq("clk_pulse_width", bad_w, 0);
        check_eq("valid_count", valid_cnt, upd ? 1 : 0);
        if (upd) check_eq("tick_to_update", valid_k + 1, FRAME);
        check_eq("mid_frame_hold", hold_err, 0);
        check_eq("post_update_hold", late_err, 0);
        check_eq("buttons", got_btn, exp_new);
        shown_m    = exp_new;
        last_latch = latch_cyc;
    endtask

    task automatic poll(input logic [7:0] p, input logic [7:0] tmask);
        pressed     = p;
        toggle_mask = tmask;
        wait_latch();
        run_frame();
    endtask

    task automatic reset_mid_frame();
        int pulses = 0;
        logic prev_clk = 1'b1;
        pressed = 8'h5A;
        wait_latch();
        for (int i = 0; i < 100 && pulses < 4; i++) begin
            @(negedge clk);
            if (!pad_clk && prev_clk) pulses++;
            prev_clk = pad_clk;
        end
        check_eq("reach_bit3_low", pulses, 4);
        #2 rst = 1'b1;
        #1;
        check_eq("async_rst_pad_clk", pad_clk, 1);
        check_eq("async_rst_pad_latch", pad_latch, 0);
        check_eq("async_rst_buttons", got_btn, 8'h00);
        check_eq("async_rst_valid", buttons_valid, 0);
        repeat (3) @(negedge clk);
        rst        = 1'b0;
        last_latch = cyc;
        shown_m    = 8'h00;
        prev_m     = 8'h00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] p;
        repeat (5) @(negedge clk);
        check_eq("reset_buttons", got_btn, 8'h00);
        check_eq("reset_pad_latch", pad_latch, 0);
        check_eq("reset_pad_clk", pad_clk, 1);
        check_eq("reset_valid", buttons_valid, 0);
        rst        = 1'b0;
        last_latch = cyc;

        poll(8'h01, 8'h00);
        poll(8'h01, 8'h00);
        poll(8'h80, 8'h00);
        poll(8'h80, 8'h00);
        poll(8'hFF, 8'h00);
        poll(8'hFF, 8'h00);
        poll(8'h00, 8'h00);
        poll(8'h00, 8'h00);
        poll(8'h00, 8'h10);
        poll(8'h10, 8'h00);
        poll(8'h10, 8'h10);
        poll(8'h00, 8'h00);
        poll(8'h08, 8'h00);
        poll(8'h00, 8'h00);
        poll(8'h00, 8'h00);
        poll(8'h08, 8'h00);
        poll(8'h08, 8'h00);

        reset_mid_frame();
        poll(8'h5A, 8'h00);
        poll(8'h5A, 8'h00);

        p = 8'h5A;
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 1) == 0) p = 8'($urandom);
            poll(p, 8'h00);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/nes_pad_reader.md
Name: nes_pad_reader

Overview:
- Serial reader for the NES-style gamepad. Drives the pad's latch and clock lines and shifts in its 8 button bits.
- Presents the buttons as individual active-high level signals: left, right, down, up, select, start, a, b.
- These outputs feed the interrupt controller's button inputs directly. This block is the producer end of that button interface.
- Polls the pad at a fixed rate and holds the outputs stable between polls.

Parameters:
- HALF_PERIOD, 150, clk cycles per pad_clk half-period and per latch half-width; minimum 4.
- POLL_DIV, 416667, clk cycles between poll starts (60 Hz at 25 MHz); must be > 18*HALF_PERIOD+1, elaboration-time assertion.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- pad_data  input  1  serial data from pad, active-low (0 = pressed), asynchronous to clk
- pad_latch  output  1  latch strobe to pad, active-high
- pad_clk  output  1  shift clock to pad; idles high; pad shifts on rising edge
- a  output  1  button A, active-high
- b  output  1  button B
- select  output  1  Select
- start  output  1  Start
- up  output  1  D-pad up
- down  output  1  D-pad down
- left  output  1  D-pad left
- right  output  1  D-pad right
- buttons_valid  output  1  one-cycle pulse when button outputs update

Behaviour:
- Clock and reset: one clock domain (clk). rst is asynchronous and active-high.
- Reset values: all button outputs 0, buttons_valid 0, pad_latch 0, pad_clk 1. FSM goes to IDLE; poll counter, bit counter and phase counter clear to 0; synchroniser flops set to 1 (released).
- pad_data synchronisation: passed through a 2-flop synchroniser. All sampling uses the synchronised value.
- Poll counter: free-running 0..POLL_DIV-1, wraps to 0. The cycle where the count equals POLL_DIV-1 is the "poll tick". First poll tick is POLL_DIV cycles after reset release.
- FSM states:
  - IDLE: pad_latch=0, pad_clk=1. On poll tick -> LATCH.
  - LATCH: pad_latch=1, pad_clk=1 for 2*HALF_PERIOD cycles, then -> LOW with bit index 0.
  - LOW: pad_latch=0, pad_clk=0 for HALF_PERIOD cycles. On the last cycle, sample ~sync_data into shift bit [index], then -> HIGH.
  - HIGH: pad_clk=1 for HALF_PERIOD cycles. If index==7 -> UPDATE, else index+1 -> LOW.
  - UPDATE: one cycle. Register the outputs from the shift register: bit0=a, 1=b, 2=select, 3=start, 4=up, 5=down, 6=left, 7=right. buttons_valid=1 this cycle only. -> IDLE.
- Frame length: poll tick to UPDATE = 18*HALF_PERIOD+1 cycles. Exactly 8 pad_clk low pulses per frame.
- Outputs hold their values between UPDATE cycles. There are no glitches mid-frame; the shift register is internal.
- A poll tick arriving outside IDLE is ignored. This cannot happen under the parameter constraint.
- Reset mid-frame: pad_latch drops to 0 and pad_clk returns to 1 immediately (asynchronously). Outputs go to 0, the partial frame is discarded, and the poll counter restarts.
- Multiple simultaneous presses are reported as-is. Priority and rejection are the downstream decoder's concern.

Optional Feature:
- Macro: NES_PAD_DEBOUNCE_EN.
- Defined:
  - The block keeps the previous frame's 8-bit sample.
  - At UPDATE, outputs are written and buttons_valid pulses only if the new sample equals the previous sample.
  - The previous sample is always overwritten with the new one.
  - Reset clears the previous sample to 0.
  - A change therefore needs two identical consecutive polls to appear.
- Undefined:
  - Every UPDATE writes the outputs and pulses buttons_valid.

Test Plan (bench parameters HALF_PERIOD=4, POLL_DIV=100; frame = 73 cycles):
- Reset check: assert rst for 5 cycles -> all buttons 0, pad_latch 0, pad_clk 1, buttons_valid 0; first pad_latch rise 100 cycles after release.
- Pad model pressing only A (drives 0 for bit 0, 1 for bits 1-7) -> after first UPDATE, a=1 and all others 0; buttons_valid is one cycle wide, 73 cycles after the poll tick; pad_latch high for exactly 8 cycles; 8 pad_clk low pulses of 4 cycles each.
- Model pressing only Right (bit 7 low) -> right=1, all others 0. Model pressing all buttons -> all 8 outputs 1. Release all -> all 0 at the next UPDATE.
- Assert rst during the LOW phase of bit 3 -> pad_clk 1 and pad_latch 0 in the same cycle, outputs 0; the next frame completes normally with the correct values.
- Inter-poll hold: model toggles Up mid-interval -> up changes only at an UPDATE; buttons_valid pulses every 100 cycles.
- With NES_PAD_DEBOUNCE_EN: Start pressed for a single poll -> start stays 0 and no buttons_valid pulse. Pressed for two polls -> start=1 at the second UPDATE.
